cmpl_acc_dump: RTL and testbench

- Complex integrate-and-dump stage placed directly downstream of the complex add/sub block (cmplAdsu).
- Consumes its ovalid/result_r/result_i stream and sums ACC_LEN valid samples per block.
- Emits one scaled complex sum per block with a single-cycle valid pulse.
- Used for block averaging and coherent integration ahead of detection logic.

---
 rtl/cmpl_acc_dump.sv | 142 ++++++++++++++
 tb/tb_cmpl_acc_dump.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmpl_acc_dump.sv
// cmpl_acc_dump: complex integrate-and-dump stage.
// Sums ACC_LEN valid complex samples per block, then presents the sum,
// arithmetically shifted right by SHIFT and narrowed to WIDTH_O, with a
// one-cycle ovalid pulse.
//
// Optional build macro CMPL_ACC_SAT_EN: when defined, the shifted sum
// saturates to the WIDTH_O signed range. When undefined, it wraps, keeping
// only the low WIDTH_O bits.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   clear     in   synchronous abort of the partial block (beats ivalid)
//   ivalid    in   input sample valid
//   data_r/i  in   signed WIDTH_I real/imaginary sample
//   ovalid    out  one-cycle pulse when a block result is presented
//   result_r/i out signed WIDTH_O block result, held between pulses
//   count     out  number of samples in the current partial block
//
// State   | meaning
// EMPTY   | no samples held, count == 0
// ACCUM   | partial block held, 0 < count < ACC_LEN
module cmpl_acc_dump #(
  parameter int WIDTH_I = 16,
  parameter int WIDTH_O = 16,
  parameter int ACC_LEN = 4,
  parameter int SHIFT   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       ivalid,
  input  logic [WIDTH_I-1:0]         data_r,
  input  logic [WIDTH_I-1:0]         data_i,
  output logic                       ovalid,
  output logic [WIDTH_O-1:0]         result_r,
  output logic [WIDTH_O-1:0]         result_i,
  output logic [$clog2(ACC_LEN):0]   count
);

  localparam int LG    = $clog2(ACC_LEN);
  localparam int CW    = LG + 1;
  localparam int ACC_W = WIDTH_I + LG;
  // Extended width covers both the accumulator and the output range, plus a
  // sign bit, so saturation compares and wrap truncation are both exact.
  localparam int EW    = ((ACC_W > WIDTH_O) ? ACC_W : WIDTH_O) + 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

  typedef enum logic {EMPTY, ACCUM} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            count_d;
  logic signed [ACC_W-1:0]  acc_r_q, acc_i_q, acc_r_d, acc_i_d;
  logic signed [ACC_W-1:0]  in_r, in_i, sum_r, sum_i;
  logic signed [EW-1:0]     ext_r, ext_i, sh_r, sh_i;
  logic [WIDTH_O-1:0]       res_r_d, res_i_d;
  logic                     dump;

  function automatic logic [WIDTH_O-1:0] narrow(input logic signed [EW-1:0] v);
`ifdef CMPL_ACC_SAT_EN
    logic signed [EW-1:0] hi, lo;
    hi = {{(EW-WIDTH_O+1){1'b0}}, {(WIDTH_O-1){1'b1}}};
    lo = {{(EW-WIDTH_O+1){1'b1}}, {(WIDTH_O-1){1'b0}}};
    if (v > hi)      narrow = hi[WIDTH_O-1:0];
    else if (v < lo) narrow = lo[WIDTH_O-1:0];
    else             narrow = v[WIDTH_O-1:0];
`else
    narrow = v[WIDTH_O-1:0];
`endif
  endfunction

  // Datapath: the running sum plus the current sample, and its scaled result.
  always_comb begin
    in_r    = ACC_W'($signed(data_r));
    in_i    = ACC_W'($signed(data_i));
    sum_r   = acc_r_q + in_r;
    sum_i   = acc_i_q + in_i;
    ext_r   = EW'(sum_r);
    ext_i   = EW'(sum_i);
    sh_r    = ext_r >>> SHIFT;
    sh_i    = ext_i >>> SHIFT;
    res_r_d = narrow(sh_r);
    res_i_d = narrow(sh_i);
  end

  always_comb begin
    state_d = state_q;
    count_d = count;
    acc_r_d = acc_r_q;
    acc_i_d = acc_i_q;
    dump    = 1'b0;
    if (clear) begin
      state_d = EMPTY;
      count_d = '0;
    end else if (ivalid) begin
      case (state_q)
        EMPTY: begin
          // First sample replaces the stale sum rather than adding to it.
          acc_r_d = in_r;
          acc_i_d = in_i;
          count_d = CW'(1);
          state_d = ACCUM;
        end
        ACCUM: begin
          acc_r_d = sum_r;
          acc_i_d = sum_i;
          if (count == LAST) begin
            dump    = 1'b1;
            count_d = '0;
            state_d = EMPTY;
          end else begin
            count_d = count + CW'(1);
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      count    <= '0;
      acc_r_q  <= '0;
      acc_i_q  <= '0;
      ovalid   <= 1'b0;
      result_r <= '0;
      result_i <= '0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      acc_r_q <= acc_r_d;
      acc_i_q <= acc_i_d;
      ovalid  <= dump;
      if (dump) begin
        result_r <= res_r_d;
        result_i <= res_i_d;
      end
    end
  end

endmodule

// File: tb/tb_cmpl_acc_dump.sv
module tb_cmpl_acc_dump;
  localparam int ACC_LEN = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        ivalid = 1'b0;
  logic [15:0] data_r = '0;
  logic [15:0] data_i = '0;

  logic        ov0, ov2;
  logic [15:0] res_r0, res_i0, res_r2, res_i2;
  logic [2:0]  cnt0, cnt2;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  int q_r[$];
  int q_i[$];
  int e_ov = 0, e_cnt = 0;
  int e_r0 = 0, e_i0 = 0, e_r2 = 0, e_i2 = 0;

  always #5 clock = ~clock;

  cmpl_acc_dump #(.WIDTH_I(16), .WIDTH_O(16), .ACC_LEN(ACC_LEN), .SHIFT(0)) u0 (
    .clock(clock), .reset(reset), .clear(clear), .ivalid(ivalid),
    .data_r(data_r), .data_i(data_i), .ovalid(ov0),
    .result_r(res_r0), .result_i(res_i0), .count(cnt0));

  cmpl_acc_dump #(.WIDTH_I(16), .WIDTH_O(16), .ACC_LEN(ACC_LEN), .SHIFT(2)) u2 (
    .clock(clock), .reset(reset), .clear(clear), .ivalid(ivalid),
    .data_r(data_r), .data_i(data_i), .ovalid(ov2),
    .result_r(res_r2), .result_i(res_i2), .count(cnt2));

  // Narrowing of an exact integer to a signed 16-bit result.
  function automatic int narrow(longint v);
`ifdef CMPL_ACC_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
`else
    longint m;
    m = v % 65536;
    if (m < 0) m += 65536;
    if (m >= 32768) m -= 65536;
    return int'(m);
`endif
  endfunction

  // Division by 2**sh rounding toward minus infinity.
  function automatic longint floor_div(longint v, int sh);
    longint d, q;
    d = longint'(1) << sh;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q -= 1;
    return q;
  endfunction

  task automatic check(string tag, longint obs, longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ovalid0", longint'(ov0), e_ov);
    check("ovalid2", longint'(ov2), e_ov);
    check("count0", longint'(cnt0), e_cnt);
    check("count2", longint'(cnt2), e_cnt);
    check("res_r0", longint'($signed(res_r0)), e_r0);
    check("res_i0", longint'($signed(res_i0)), e_i0);
    check("res_r2", longint'($signed(res_r2)), e_r2);
    check("res_i2", longint'($signed(res_i2)), e_i2);
  endtask

  // One clock: drive inputs, advance, update the block model, compare.
  task automatic step(bit v, bit c, int dr, int di);
    longint sr, si;
    ivalid = v;
    clear  = c;
    data_r = 16'(dr);
    data_i = 16'(di);
    @(posedge clock);
    #1;
    e_ov = 0;
    if (c) begin
      q_r.delete();
      q_i.delete();
    end else if (v) begin
      q_r.push_back(dr);
      q_i.push_back(di);
      if (q_r.size() == ACC_LEN) begin
        sr = 0;
        si = 0;
        foreach (q_r[k]) begin
          sr += q_r[k];
          si += q_i[k];
        end
        e_r0 = narrow(sr);
        e_i0 = narrow(si);
        e_r2 = narrow(floor_div(sr, 2));
        e_i2 = narrow(floor_div(si, 2));
        e_ov = 1;
        q_r.delete();
        q_i.delete();
      end
    end
    e_cnt = q_r.size();
    if (ov0) pulses++;
    check_all();
    ivalid = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    q_r.delete();
    q_i.delete();
    e_ov = 0; e_cnt = 0;
    e_r0 = 0; e_i0 = 0; e_r2 = 0; e_i2 = 0;
    check_all();
    @(posedge clock);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    int dr, di;
    bit v, c;

    // Reset state
    #1;
    check_all();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_all();

    // Basic sum
    step(1, 0, 4, 6);
    step(1, 0, 12, 14);
    step(1, 0, 1, 1);
    step(1, 0, -2, 3);
    check("basic_r", longint'($signed(res_r0)), 15);
    check("basic_i", longint'($signed(res_i0)), 24);
    check("basic_ov", longint'(ov0), 1);
    check("basic_cnt", longint'(cnt0), 0);
    step(0, 0, 0, 0);
    check("basic_ov_drop", longint'(ov0), 0);
    check("basic_hold_r", longint'($signed(res_r0)), 15);

    // Averaging with SHIFT=2
    repeat (4) step(1, 0, 8, -8);
    check("avg_r", longint'($signed(res_r2)), 8);
    check("avg_i", longint'($signed(res_i2)), -8);
    repeat (3) step(1, 0, 1, 1);
    step(1, 0, 0, 0);
    check("avg_small_r", longint'($signed(res_r2)), 0);
    check("avg_small_i", longint'($signed(res_i2)), 0);

    // Gapped then back-to-back
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 1, 2);
      if (k < 3) step(0, 0, 77, 77);
    end
    repeat (8) step(1, 0, 1, 2);
    step(0, 0, 0, 0);
    check("gap_pulses", pulses, 3);
    check("gap_r", longint'($signed(res_r0)), 4);
    check("gap_i", longint'($signed(res_i0)), 8);

    // Clear handling
    pulses = 0;
    step(1, 0, 5, 5);
    step(1, 0, 5, 5);
    step(1, 1, 5, 5);
    check("clr_cnt", longint'(cnt0), 0);
    repeat (4) step(1, 0, 1, 1);
    check("clr_r", longint'($signed(res_r0)), 4);
    check("clr_i", longint'($signed(res_i0)), 4);
    repeat (3) step(1, 0, 1, 1);
    step(1, 1, 1, 1);
    step(0, 0, 0, 0);
    check("clr_last_pulses", pulses, 1);

    // Overflow
    repeat (4) step(1, 0, 32767, -32768);
`ifdef CMPL_ACC_SAT_EN
    check("ovf_r", longint'($signed(res_r0)), 32767);
    check("ovf_i", longint'($signed(res_i0)), -32768);
`else
    check("ovf_r", longint'($signed(res_r0)), -4);
    check("ovf_i", longint'($signed(res_i0)), 0);
`endif

    // Reset mid-block
    repeat (3) step(1, 0, 9, 9);
    pulses = 0;
    pulse_reset();
    repeat (4) step(1, 0, 2, 2);
    step(0, 0, 0, 0);
    check("rst_pulses", pulses, 1);
    check("rst_r", longint'($signed(res_r0)), 8);
    check("rst_i", longint'($signed(res_i0)), 8);

    // Randomized traffic against the block model
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) begin
        dr = int'($signed(16'($urandom)));
        di = int'($signed(16'($urandom)));
      end else begin
        dr = int'($urandom_range(0, 20)) - 10;
        di = int'($urandom_range(0, 20)) - 10;
      end
      step(v, c, dr, di);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
